rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we3/wa3/wd3) among NREQ writeback sources, e.g. ALU, load unit and multi-cycle mul/div.
- Each source has a 1-entry holding buffer with a valid/ready handshake.
- An age-matrix arbiter drains the oldest buffered write, one write per clock.
- Sits between the execute/memory writeback stages and the register file.

---
 rtl/rf_wb_arbiter_pkg.sv | 26 ++
 rtl/rf_wb_arbiter_age_matrix_arb.sv | 59 +++++
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared constants for the register-file writeback arbiter slice.
//   RFWB_XLEN  : datapath width (matches the core XLEN)
//   RFWB_RIDX  : register index width
//   RFWB_NREQ  : default number of writeback requesters
//   RFREG_NUM  : number of architectural registers
// Helper reg_onehot() decodes a register index to a pending-mask bit vector,
// with x0 never reported as pending.
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

    localparam int RFWB_XLEN = 32;
    localparam int RFWB_RIDX = 5;
    localparam int RFWB_NREQ = 3;
    localparam int RFREG_NUM = 32;

    function automatic logic [RFREG_NUM-1:0] reg_onehot(input logic [RFWB_RIDX-1:0] idx);
        logic [RFREG_NUM-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        oh[0]   = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_age_matrix_arb.sv
// ---------------------------------------------------------------------------
// age_matrix_arb
// Oldest-first arbiter built on an N x N age matrix. older[i][j] = 1 means
// entry i was pushed strictly before entry j. Entries pushed on the same
// edge are ordered by index (lower index is older).
// Ports:
//   clk, rstn : clock, asynchronous active-low reset (clears the matrix)
//   valid[N]  : entry currently occupied
//   push[N]   : entry is (re)filled at this edge; it becomes youngest
//   pop[N]    : entry is drained at this edge
//   grant[N]  : one-hot, the oldest valid entry (all zero when none valid)
// ---------------------------------------------------------------------------
module age_matrix_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] valid,
    input  logic [N-1:0] push,
    input  logic [N-1:0] pop,
    output logic [N-1:0] grant
);

    logic [N-1:0] older [N];
    logic [N-1:0] blocked;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i == j) begin
                        older[i][j] <= 1'b0;
                    end else if (push[i] && push[j]) begin
                        older[i][j] <= (i < j);
                    end else if (push[i]) begin
                        older[i][j] <= 1'b0;
                    end else if (push[j]) begin
                        // A surviving entry is older than anything newly pushed.
                        older[i][j] <= valid[i] & ~pop[i];
                    end
                end
            end
        end
    end

    // Stale matrix bits of empty entries are harmless: they are masked by valid.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i != j && valid[j] && older[j][i]) blocked[i] = 1'b1;
            end
        end
        grant = valid & ~blocked;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port among NREQ writeback sources.
// Each source owns a 1-entry holding buffer (valid/ready handshake); the
// oldest buffered write is drained to the regfile, one per clock.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (accept on valid&ready)
//   req_addr/req_data    : packed per-requester destination and data
//   we3/wa3/wd3          : register-file write port
//   pend_mask            : registers targeted by any buffered write
//   busy                 : any buffer occupied
// Build option: define RFWB_PENDMASK_EN to compute pend_mask; otherwise it
// is tied to zero and its decode is removed.
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = RFWB_NREQ,
    parameter int XLEN = RFWB_XLEN,
    parameter int RIDX = RFWB_RIDX
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*RIDX-1:0] req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 we3,
    output logic [RIDX-1:0]      wa3,
    output logic [XLEN-1:0]      wd3,
    output logic [31:0]          pend_mask,
    output logic                 busy
);

    logic [NREQ-1:0] buf_valid;
    logic [RIDX-1:0] buf_addr [NREQ];
    logic [XLEN-1:0] buf_data [NREQ];
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] accept;
    logic [RIDX-1:0] g_addr;
    logic [XLEN-1:0] g_data;

    // A draining buffer can be refilled on the same edge.
    assign req_ready = ~buf_valid | grant;
    assign accept    = req_valid & req_ready;

    // ---- holding buffers ---------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_valid <= '0;
        end else begin
            buf_valid <= (buf_valid & ~grant) | accept;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                buf_addr[i] <= req_addr[i*RIDX +: RIDX];
                buf_data[i] <= req_data[i*XLEN +: XLEN];
            end
        end
    end

    age_matrix_arb #(
        .N (NREQ)
    ) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .valid (buf_valid),
        .push  (accept),
        .pop   (grant),
        .grant (grant)
    );

    // ---- regfile write port ------------------------------------------------
    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_addr = g_addr | buf_addr[i];
                g_data = g_data | buf_data[i];
            end
        end
    end

    // x0 writes still drain in order but never strobe the regfile.
    assign we3  = (|grant) && (g_addr != '0);
    assign wa3  = g_addr;
    assign wd3  = g_data;
    assign busy = |buf_valid;

`ifdef RFWB_PENDMASK_EN
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (buf_valid[i]) pend_mask = pend_mask | reg_onehot(buf_addr[i]);
        end
    end
`else
    assign pend_mask = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pend_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] d;
        logic [2:0]  exp_ready;
        logic        exp_busy;
    } vec_t;

    typedef struct {
        int          src;
        logic [4:0]  addr;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbq[$];
    logic [31:0] shadow_rf [32];

    rf_wb_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .pend_mask (pend_mask),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Only the head entry may drain, so every other queued source is blocked.
    function automatic logic [2:0] m_ready();
        logic [2:0] r;
        r = 3'b111;
        for (int k = 1; k < sbq.size(); k++) r[sbq[k].src] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p;
        p = '0;
`ifdef RFWB_PENDMASK_EN
        for (int k = 0; k < sbq.size(); k++)
            if (sbq[k].addr != 5'd0) p[sbq[k].addr] = 1'b1;
`endif
        return p;
    endfunction

    // Called just after a falling edge: drive, check, cross one rising edge.
    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                        input logic has_tbl, input logic [2:0] t_ready, input logic t_busy,
                        input string tag);
        logic [2:0]  mr;
        logic [2:0]  acc;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
        mr   = m_ready();
        e_we = 1'b0;
        e_wa = '0;
        e_wd = '0;
        if (sbq.size() > 0) begin
            e_wa = sbq[0].addr;
            e_wd = sbq[0].data;
            e_we = (sbq[0].addr != 5'd0);
        end
        chk($sformatf("%s.we3", tag), {31'd0, we3}, {31'd0, e_we});
        chk($sformatf("%s.wa3", tag), {27'd0, wa3}, {27'd0, e_wa});
        chk($sformatf("%s.wd3", tag), wd3, e_wd);
        chk($sformatf("%s.busy", tag), {31'd0, busy}, {31'd0, (sbq.size() != 0)});
        chk($sformatf("%s.ready", tag), {29'd0, req_ready}, {29'd0, mr});
        chk($sformatf("%s.pend", tag), pend_mask, m_pend());
        if (has_tbl) begin
            chk($sformatf("%s.tbl_ready", tag), {29'd0, req_ready}, {29'd0, t_ready});
            chk($sformatf("%s.tbl_busy", tag), {31'd0, busy}, {31'd0, t_busy});
        end
        if (we3) shadow_rf[wa3] = wd3;
        acc = v & mr;
        @(posedge clk);
        if (sbq.size() > 0) void'(sbq.pop_front());
        for (int i = 0; i < 3; i++)
            if (acc[i]) sbq.push_back('{i, a[i*5 +: 5], d[i*32 +: 32]});
        @(negedge clk);
    endtask

    task automatic add(input logic [2:0] v,
                       input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                       input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                       input logic [2:0] er, input logic eb);
        vec_t t;
        t.v = v;
        t.a = {a2, a1, a0};
        t.d = {d2, d1, d0};
        t.exp_ready = er;
        t.exp_busy  = eb;
        vecs.push_back(t);
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int r = 0; r < 32; r++) shadow_rf[r] = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.ready", {29'd0, req_ready}, 32'd7);
        chk("rst.we3", {31'd0, we3}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.wa3", {27'd0, wa3}, 32'd0);
        chk("rst.wd3", wd3, 32'd0);
        chk("rst.pend", pend_mask, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // idle
        for (int k = 0; k < 5; k++) add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b0);
        // single write x5
        add(3'b001, 0, 0, 5, 0, 0, 32'hDEADBEEF, 3'b111, 1'b0);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b0);
        // simultaneous x1/x2/x3
        add(3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b111, 1'b0);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b011, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b0);
        // same-register ordering: req2 x7=AA before req0 x7=BB
        add(3'b110, 7, 9, 0, 32'hAA, 32'h99, 0, 3'b111, 1'b0);
        add(3'b001, 0, 0, 7, 0, 0, 32'hBB, 3'b011, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b110, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b0);
        // x0 write
        add(3'b010, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 3'b111, 1'b0);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b0);
        // back-to-back drain and refill on one requester
        add(3'b001, 0, 0, 4, 0, 0, 32'h1, 3'b111, 1'b0);
        add(3'b001, 0, 0, 6, 0, 0, 32'h2, 3'b111, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b0);
        // refilled buffer becomes youngest
        add(3'b011, 0, 11, 10, 0, 32'hA1, 32'hA0, 3'b111, 1'b0);
        add(3'b001, 0, 0, 12, 0, 0, 32'hA2, 3'b101, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b110, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1'b0);

        for (int k = 0; k < vecs.size(); k++)
            step(vecs[k].v, vecs[k].a, vecs[k].d, 1'b1, vecs[k].exp_ready, vecs[k].exp_busy,
                 $sformatf("vec%0d", k));
        chk("x7_last_writer", shadow_rf[7], 32'hBB);
        chk("x5_written", shadow_rf[5], 32'hDEADBEEF);

        // random contention
        for (int k = 0; k < 60; k++)
            step(3'($urandom_range(0, 7)), 15'($urandom), {$urandom, $urandom, $urandom},
                 1'b0, 3'b000, 1'b0, $sformatf("rnd%0d", k));
        for (int k = 0; k < 6 && sbq.size() > 0; k++)
            step(3'b000, '0, '0, 1'b0, 3'b000, 1'b0, "drain");
        chk("drain_empty", sbq.size(), 32'd0);

        // asynchronous reset with two buffers occupied
        step(3'b011, {5'd0, 5'd21, 5'd20}, {32'd0, 32'h2121, 32'h2020}, 1'b0, 3'b000, 1'b0, "pre_rst");
        step(3'b100, {5'd22, 10'd0}, {32'h2222, 64'd0}, 1'b0, 3'b000, 1'b0, "pre_rst2");
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.busy", {31'd0, busy}, 32'd0);
        chk("arst.we3", {31'd0, we3}, 32'd0);
        chk("arst.ready", {29'd0, req_ready}, 32'd7);
        chk("arst.pend", pend_mask, 32'd0);
        sbq.delete();
        req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++)
            step(3'b000, '0, '0, 1'b1, 3'b111, 1'b0, $sformatf("post_rst%0d", k));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
